// File: rtl/debounce_pkg.sv
// Shared defaults and counter sizing for the multi-channel switch debouncer.
// Pure declarations: no latency, no backpressure.
package debounce_pkg;
   localparam int   DEF_N_CH         = 4;
   localparam int   DEF_TICK_DIV     = 50000;
   localparam int   DEF_STABLE_TICKS = 10;
   localparam logic DEF_INIT_LEVEL   = 1'b1;

   // Width that holds 0..stable so the count never needs to wrap.
   function automatic int cnt_width(input int stable);
      return (stable < 1) ? 1 : $clog2(stable + 1);
   endfunction
endpackage

// File: rtl/debounce_channel.sv
// One debounced input: 2-flop sync, stability counter, registered level and edge pulses.
// Accepts a new level after STABLE_TICKS mismatching ticks; no backpressure, pulses are fire-and-forget.
module debounce_channel
   import debounce_pkg::*;
#(
   parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
   parameter logic INIT_LEVEL   = DEF_INIT_LEVEL
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic tick_i,
   input  logic raw_i,
   output logic data_o,
   output logic rise_o,
   output logic fall_o
);
   localparam int            CW   = cnt_width(STABLE_TICKS);
   localparam logic [CW-1:0] LAST = CW'(STABLE_TICKS - 1);

   logic          sync1_q, sync2_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          data_q, data_d;
   logic          rise_q, rise_d;
   logic          fall_q, fall_d;

   always_comb begin
      cnt_d  = cnt_q;
      data_d = data_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      // Any matching sample, tick or not, abandons the pending change.
      if (sync2_q == data_q) begin
         cnt_d = '0;
      end else if (tick_i) begin
         if (cnt_q == LAST) begin
            data_d = ~data_q;
            cnt_d  = '0;
            rise_d = ~data_q;
            fall_d = data_q;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync1_q <= INIT_LEVEL;
         sync2_q <= INIT_LEVEL;
         cnt_q   <= '0;
         data_q  <= INIT_LEVEL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign data_o = data_q;
   assign rise_o = rise_q;
   assign fall_o = fall_q;
endmodule

// File: rtl/multi_debouncer.sv
// N_CH independent debouncers sharing one sample-tick prescaler; o_Any flags any edge this clock.
// Accept latency 2 sync clocks + (STABLE_TICKS-1)*TICK_DIV+1 .. STABLE_TICKS*TICK_DIV clocks; no backpressure.
module multi_debouncer
   import debounce_pkg::*;
#(
   parameter int   N_CH         = DEF_N_CH,
   parameter int   TICK_DIV     = DEF_TICK_DIV,
   parameter int   STABLE_TICKS = DEF_STABLE_TICKS,
   parameter logic INIT_LEVEL   = DEF_INIT_LEVEL
) (
   input  logic            i_CLK,
   input  logic            i_RST_n,
   input  logic [N_CH-1:0] i_Data,
   output logic [N_CH-1:0] o_Data,
   output logic [N_CH-1:0] o_Rise,
   output logic [N_CH-1:0] o_Fall,
   output logic            o_Any
);
   localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

   logic [PW-1:0] pre_q, pre_d;
   logic          tick;

   assign tick  = (pre_q == PW'(TICK_DIV - 1));
   assign pre_d = tick ? '0 : pre_q + PW'(1);

   always_ff @(posedge i_CLK or negedge i_RST_n) begin
      if (!i_RST_n) pre_q <= '0;
      else          pre_q <= pre_d;
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      debounce_channel #(
         .STABLE_TICKS (STABLE_TICKS),
         .INIT_LEVEL   (INIT_LEVEL)
      ) u_ch (
         .clk_i   (i_CLK),
         .rst_n_i (i_RST_n),
         .tick_i  (tick),
         .raw_i   (i_Data[k]),
         .data_o  (o_Data[k]),
         .rise_o  (o_Rise[k]),
         .fall_o  (o_Fall[k])
      );
   end

   assign o_Any = |(o_Rise | o_Fall);
endmodule

// File: tb/tb_multi_debouncer.sv
// Scoreboard bench for multi_debouncer with N_CH=4, TICK_DIV=4, STABLE_TICKS=3.
module tb_multi_debouncer;
   typedef struct {
      logic [3:0] rise;
      logic [3:0] fall;
      logic [3:0] data;
      int         lo;
      int         hi;
   } ev_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] din;
   logic [3:0] o_data, o_rise, o_fall;
   logic       o_any;

   int   cyc = 0;
   int   rel_cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic [3:0] exp_lvl = 4'hF;
   ev_t  q[$];

   multi_debouncer #(
      .N_CH(4), .TICK_DIV(4), .STABLE_TICKS(3), .INIT_LEVEL(1'b1)
   ) dut (
      .i_CLK   (clk),
      .i_RST_n (rst_n),
      .i_Data  (din),
      .o_Data  (o_data),
      .o_Rise  (o_rise),
      .o_Fall  (o_fall),
      .o_Any   (o_any)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic push(input logic [3:0] r, input logic [3:0] f,
                       input logic [3:0] d, input int lo, input int hi);
      ev_t e;
      e.rise = r; e.fall = f; e.data = d; e.lo = lo; e.hi = hi;
      q.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Returns on a negedge just after a tick edge, so a change driven now is
   // accepted exactly at posedge cyc+12.
   task automatic align(output int c);
      while (((cyc - rel_cyc) % 4) != 0) @(negedge clk);
      c = cyc;
   endtask

   // Monitor: pops an expectation whenever the DUT presents an edge.
   initial begin
      ev_t e;
      forever begin
         @(negedge clk);
         #1;
         if (!rst_n) exp_lvl = 4'hF;
         if ((o_rise | o_fall) != 4'h0 || o_any) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_pulse cyc=%0d rise=%h fall=%h any=%b data=%h",
                        cyc, o_rise, o_fall, o_any, o_data);
            end else begin
               e = q.pop_front();
               if (o_rise !== e.rise || o_fall !== e.fall || o_data !== e.data ||
                   o_any !== 1'b1 || cyc < e.lo || cyc > e.hi) begin
                  errors++;
                  $display("FAIL edge_event cyc=%0d rise=%h fall=%h data=%h any=%b required rise=%h fall=%h data=%h any=1 cyc=%0d..%0d",
                           cyc, o_rise, o_fall, o_data, o_any, e.rise, e.fall, e.data, e.lo, e.hi);
               end
               exp_lvl = e.data;
            end
         end
         checks++;
         if (o_data !== exp_lvl) begin
            errors++;
            $display("FAIL level cyc=%0d data=%h required %h", cyc, o_data, exp_lvl);
         end
      end
   end

   initial begin
      int c;
      rst_n = 1'b0;
      din   = 4'hF;
      wait_cyc(3);
      rst_n = 1'b1;
      rel_cyc = cyc;
      wait_cyc(100);

      // Single channel fall then rise, window relative to input change.
      c = cyc; din[0] = 1'b0; push(4'h0, 4'h1, 4'hE, c + 11, c + 14);
      wait_cyc(20);
      c = cyc; din[0] = 1'b1; push(4'h1, 4'h0, 4'hF, c + 11, c + 14);
      wait_cyc(20);

      // Bouncing input on channel 1: never stable across enough ticks.
      for (int i = 0; i < 66; i++) begin
         din[1] = ~din[1];
         wait_cyc(3);
      end
      wait_cyc(20);

      // Two channels switching together.
      c = cyc; din[3:2] = 2'b00; push(4'h0, 4'hC, 4'h3, c + 11, c + 14);
      wait_cyc(20);
      c = cyc; din[3:2] = 2'b11; push(4'hC, 4'h0, 4'hF, c + 11, c + 14);
      wait_cyc(20);

      // Reset after two mismatching ticks discards the pending change.
      align(c);
      din[0] = 1'b0;
      wait_cyc(10);
      rst_n = 1'b0;
      wait_cyc(3);
      rst_n = 1'b1;
      rel_cyc = cyc;
      push(4'h0, 4'h1, 4'hE, rel_cyc + 12, rel_cyc + 12);
      wait_cyc(20);
      align(c);
      din[0] = 1'b1; push(4'h1, 4'h0, 4'hF, c + 12, c + 12);
      wait_cyc(20);

      // One-clock glitch on a non-tick edge after two ticks restarts the count.
      align(c);
      din[0] = 1'b0;
      wait_cyc(8);
      din[0] = 1'b1;
      wait_cyc(1);
      din[0] = 1'b0;
      push(4'h0, 4'h1, 4'hE, c + 20, c + 20);
      wait_cyc(20);
      align(c);
      din[0] = 1'b1; push(4'h1, 4'h0, 4'hF, c + 12, c + 12);
      wait_cyc(20);

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL missing_events pending=%0d required 0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/multi_debouncer.md
MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent input channels, legal range 1..32.
REQ-002 SHALL have parameter TICK_DIV, default 50000: clocks per shared sample tick (1 ms at 50 MHz), legal range >=2.
REQ-003 SHALL have parameter STABLE_TICKS, default 10: consecutive mismatching ticks required to accept a new level, legal range >=1.
REQ-004 SHALL have parameter INIT_LEVEL, default 1: reset level of every debounced output and synchronizer stage.
REQ-005 SHALL have port i_CLK, input, 1 bit: the single clock; all state on its rising edge.
REQ-006 SHALL have port i_RST_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 SHALL have port i_Data, input, N_CH bits: raw asynchronous switch/button levels.
REQ-008 SHALL have port o_Data, output reg, N_CH bits: debounced levels.
REQ-009 SHALL have port o_Rise, output reg, N_CH bits: one-cycle pulse when o_Data[k] goes 0->1.
REQ-010 SHALL have port o_Fall, output reg, N_CH bits: one-cycle pulse when o_Data[k] goes 1->0.
REQ-011 SHALL have port o_Any, output, 1 bit: OR of o_Rise and o_Fall, combinational.

Function
REQ-012 SHALL pass each i_Data[k] through a 2-flop synchronizer; the second stage is s[k].
REQ-013 SHALL run one shared prescaler counting 0..TICK_DIV-1, wrapping to 0, asserting internal tick for one clock when at TICK_DIV-1.
REQ-014 SHALL keep per channel a counter cnt[k] of width $clog2(STABLE_TICKS+1).
REQ-015 SHALL clear cnt[k] on any clock where s[k]==o_Data[k], regardless of tick; a single matching sample aborts the pending change.
REQ-016 SHALL increment cnt[k] on tick when s[k]!=o_Data[k] and cnt[k]<STABLE_TICKS-1.
REQ-017 SHALL, on tick when s[k]!=o_Data[k] and cnt[k]==STABLE_TICKS-1, invert o_Data[k], clear cnt[k], and assert o_Rise[k] or o_Fall[k] on that edge.
REQ-018 SHALL hold o_Rise/o_Fall high exactly one clock; pulses SHALL be registered, coincident with the o_Data change.
REQ-019 SHALL treat channels independently; simultaneous acceptance on several channels in one tick SHALL produce simultaneous pulses.
REQ-020 SHALL never let cnt[k] exceed STABLE_TICKS-1 (no wrap).
REQ-021 Worst-case accept latency from a stable i_Data change: 2 sync clocks + up to STABLE_TICKS*TICK_DIV clocks; minimum (STABLE_TICKS-1)*TICK_DIV+1 clocks after sync.

Reset
REQ-022 SHALL, while i_RST_n=0, force o_Data and both synchronizer stages to INIT_LEVEL on all bits, o_Rise=o_Fall=0, all cnt=0, prescaler=0.
REQ-023 SHALL, on reset assertion mid-count, discard pending changes without emitting pulses.
REQ-024 SHALL deassert reset synchronously at the system level; the block SHALL produce no pulse in the first clock after release.

Structure
REQ-025 SHALL place default parameter values and the counter-width function in shared package debounce_pkg.
REQ-026 SHALL implement one channel (synchronizer, cnt, output, pulses) as sub-module debounce_channel, instantiated N_CH times via generate; prescaler stays in the top.

Verification (N_CH=4, TICK_DIV=4, STABLE_TICKS=3, INIT_LEVEL=1)
REQ-027 Reset with i_Data=4'hF, release, hold 100 clocks -> o_Data=4'hF, no pulses, o_Any=0 throughout.
REQ-028 Drive i_Data[0]=0 steady -> o_Data[0] falls 9..12 clocks after sync, o_Fall[0]=1 for exactly one clock, other channels unchanged.
REQ-029 Toggle i_Data[1] every 3 clocks for 200 clocks -> o_Data[1] stays 1, o_Fall[1] never asserts.
REQ-030 Drive i_Data[3:2]=2'b00 on the same clock -> o_Fall[3] and o_Fall[2] pulse on the same clock; later 2'b11 -> simultaneous o_Rise[3:2].
REQ-031 Drive i_Data[0]=0, assert i_RST_n=0 after 2 ticks, release -> o_Data[0]=1, no pulse, counter restarts from 0.
REQ-032 Single-clock glitch back to old level after 2 mismatching ticks -> cnt cleared; change accepted only after 3 further full ticks.
